// File: rtl/csa_addsub_pipe_pkg.sv
// ---------------------------------------------------------------------------
// csa_addsub_pipe_pkg
//   Shared definitions for the pipelined carry-select adder/subtractor:
//   operation encoding and the derived block/stage count helpers.
// ---------------------------------------------------------------------------
package csa_addsub_pipe_pkg;

   typedef enum logic {
      MODE_ADD = 1'b0,
      MODE_SUB = 1'b1
   } mode_e;

   // Number of carry-select blocks across the full operand width.
   function automatic int unsigned calc_nblocks(input int unsigned data_width,
                                                input int unsigned block_width);
      return data_width / block_width;
   endfunction

   // Number of pipeline stages; each stage resolves blocks_per_stage blocks.
   function automatic int unsigned calc_nstages(input int unsigned data_width,
                                                input int unsigned block_width,
                                                input int unsigned blocks_per_stage);
      return data_width / (block_width * blocks_per_stage);
   endfunction

endpackage

// File: rtl/csa_addsub_pipe_select.sv
// ---------------------------------------------------------------------------
// csa_select_block
//   Combinational carry-select block: both sums (carry-in 0 and carry-in 1)
//   are formed in parallel and the incoming carry picks one.
//   Ports:
//     a, b  - block operand slices
//     cin   - incoming block carry (select)
//     sum   - selected block sum
//     cout  - selected block carry-out
// ---------------------------------------------------------------------------
module csa_select_block #(
   parameter int unsigned BLOCK_WIDTH = 2
) (
   input  logic [BLOCK_WIDTH-1:0] a,
   input  logic [BLOCK_WIDTH-1:0] b,
   input  logic                   cin,
   output logic [BLOCK_WIDTH-1:0] sum,
   output logic                   cout
);

   logic [BLOCK_WIDTH:0] sum_c0;
   logic [BLOCK_WIDTH:0] sum_c1;

   always_comb begin
      sum_c0 = {1'b0, a} + {1'b0, b};
      sum_c1 = {1'b0, a} + {1'b0, b} + (BLOCK_WIDTH+1)'(1);
      {cout, sum} = cin ? sum_c1 : sum_c0;
   end

endmodule

// File: rtl/csa_addsub_pipe.sv
// ---------------------------------------------------------------------------
// csa_addsub_pipe
//   Pipelined carry-select adder/subtractor with valid/ready handshaking.
//   Each stage resolves BLOCKS_PER_STAGE carry-select blocks and registers
//   the partial sum, the block carry, the mode and the operand bits that
//   later stages still need. Subtract is in1 + ~in2 + !cin with the final
//   carry inverted into a borrow.
//   Ports:
//     clk, rst_n           - clock, synchronous active-low reset
//     in_valid / in_ready  - input beat handshake
//     mode                 - 0 add, 1 subtract (per beat)
//     in1, in2, cin        - operands and carry/borrow-in
//     out_valid / out_ready- output beat handshake
//     result               - {carry/borrow-out, sum}
// ---------------------------------------------------------------------------
module csa_addsub_pipe
   import csa_addsub_pipe_pkg::*;
#(
   parameter int unsigned DATA_WIDTH       = 16,
   parameter int unsigned BLOCK_WIDTH      = 2,
   parameter int unsigned BLOCKS_PER_STAGE = 2
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic                  mode,
   input  logic [DATA_WIDTH-1:0] in1,
   input  logic [DATA_WIDTH-1:0] in2,
   input  logic                  cin,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [DATA_WIDTH:0]   result
);

   localparam int unsigned NBLOCKS = calc_nblocks(DATA_WIDTH, BLOCK_WIDTH);
   localparam int unsigned NSTAGES = calc_nstages(DATA_WIDTH, BLOCK_WIDTH, BLOCKS_PER_STAGE);
   localparam int unsigned SW      = BLOCK_WIDTH * BLOCKS_PER_STAGE;
   localparam int unsigned LAST    = NSTAGES - 1;

   // Stage registers
   logic [NSTAGES-1:0]    valid_q, valid_d;
   logic [DATA_WIDTH-1:0] a_q   [NSTAGES];
   logic [DATA_WIDTH-1:0] a_d   [NSTAGES];
   logic [DATA_WIDTH-1:0] b_q   [NSTAGES];
   logic [DATA_WIDTH-1:0] b_d   [NSTAGES];
   logic [DATA_WIDTH-1:0] sum_q [NSTAGES];
   logic [DATA_WIDTH-1:0] sum_d [NSTAGES];
   logic                  carry_q [NSTAGES];
   logic                  carry_d [NSTAGES];
   mode_e                 mode_q  [NSTAGES];
   mode_e                 mode_d  [NSTAGES];

   // Per-stage inputs (previous stage registers, or the ports for stage 0)
   logic                  src_v    [NSTAGES];
   logic [DATA_WIDTH-1:0] src_a    [NSTAGES];
   logic [DATA_WIDTH-1:0] src_b    [NSTAGES];
   logic [DATA_WIDTH-1:0] src_sum  [NSTAGES];
   logic                  src_c    [NSTAGES];
   mode_e                 src_mode [NSTAGES];

   // Per-stage combinational block results
   logic [SW-1:0]         stage_sum  [NSTAGES];
   logic                  stage_cout [NSTAGES];

   // Handshake
   logic [NSTAGES-1:0]    rdy_out;
   logic [NSTAGES-1:0]    load_ok;

   // Operand conditioning happens once at entry; later stages see a plain add.
   always_comb begin
      for (int unsigned s = 0; s < NSTAGES; s++) begin
         if (s == 0) begin
            src_v[s]    = in_valid;
            src_a[s]    = in1;
            src_b[s]    = (mode == MODE_SUB) ? ~in2 : in2;
            src_c[s]    = (mode == MODE_SUB) ? ~cin : cin;
            src_sum[s]  = '0;
            src_mode[s] = mode_e'(mode);
         end else begin
            src_v[s]    = valid_q[s-1];
            src_a[s]    = a_q[s-1];
            src_b[s]    = b_q[s-1];
            src_c[s]    = carry_q[s-1];
            src_sum[s]  = sum_q[s-1];
            src_mode[s] = mode_q[s-1];
         end
      end
   end

   for (genvar s = 0; s < NSTAGES; s++) begin : g_stage
      logic [BLOCKS_PER_STAGE:0] chain;
      logic [SW-1:0]             blk_sum;

      assign chain[0] = src_c[s];

      for (genvar j = 0; j < BLOCKS_PER_STAGE; j++) begin : g_blk
         localparam int unsigned IDX = s * BLOCKS_PER_STAGE + j;
         if (IDX < NBLOCKS) begin : g_inst
            csa_select_block #(
               .BLOCK_WIDTH (BLOCK_WIDTH)
            ) u_blk (
               .a    (src_a[s][IDX*BLOCK_WIDTH +: BLOCK_WIDTH]),
               .b    (src_b[s][IDX*BLOCK_WIDTH +: BLOCK_WIDTH]),
               .cin  (chain[j]),
               .sum  (blk_sum[j*BLOCK_WIDTH +: BLOCK_WIDTH]),
               .cout (chain[j+1])
            );
         end
      end

      assign stage_sum[s]  = blk_sum;
      assign stage_cout[s] = chain[BLOCKS_PER_STAGE];
   end

   // Ready ripples backwards from out_ready; a running variable keeps each
   // vector free of self-referencing bits.
   always_comb begin
      logic rdy;
      rdy_out = '0;
      load_ok = '0;
      rdy     = out_ready;
      for (int unsigned i = 0; i < NSTAGES; i++) begin
         int unsigned idx;
         idx          = NSTAGES - 1 - i;
         rdy_out[idx] = rdy;
         load_ok[idx] = ~valid_q[idx] | rdy;
         rdy          = load_ok[idx];
      end
   end

   always_comb begin
      valid_d = valid_q;
      for (int unsigned s = 0; s < NSTAGES; s++) begin
         a_d[s]     = a_q[s];
         b_d[s]     = b_q[s];
         sum_d[s]   = sum_q[s];
         carry_d[s] = carry_q[s];
         mode_d[s]  = mode_q[s];
         if (load_ok[s]) begin
            valid_d[s] = src_v[s];
         end
         // Payload only changes on a real load, so empty-stage contents never
         // disturb a held result.
         if (load_ok[s] && src_v[s]) begin
            a_d[s]                 = src_a[s];
            b_d[s]                 = src_b[s];
            sum_d[s]               = src_sum[s];
            sum_d[s][s*SW +: SW]   = stage_sum[s];
            carry_d[s]             = stage_cout[s];
            mode_d[s]              = src_mode[s];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         valid_q <= '0;
         for (int unsigned s = 0; s < NSTAGES; s++) begin
            a_q[s]     <= '0;
            b_q[s]     <= '0;
            sum_q[s]   <= '0;
            carry_q[s] <= 1'b0;
            mode_q[s]  <= MODE_ADD;
         end
      end else begin
         valid_q <= valid_d;
         for (int unsigned s = 0; s < NSTAGES; s++) begin
            a_q[s]     <= a_d[s];
            b_q[s]     <= b_d[s];
            sum_q[s]   <= sum_d[s];
            carry_q[s] <= carry_d[s];
            mode_q[s]  <= mode_d[s];
         end
      end
   end

   assign in_ready  = rst_n & load_ok[0];
   assign out_valid = valid_q[LAST];
   assign result    = {carry_q[LAST] ^ (mode_q[LAST] == MODE_SUB), sum_q[LAST]};

endmodule

// File: doc/csa_addsub_pipe.md
CSA_ADDSUB_PIPE -- requirements
Module: csa_addsub_pipe

Interface
REQ-001 Parameter DATA_WIDTH, default 16: operand width in bits; SHALL be a multiple of BLOCK_WIDTH.
REQ-002 Parameter BLOCK_WIDTH, default 2: bits per carry-select block.
REQ-003 Parameter BLOCKS_PER_STAGE, default 2: carry-select blocks evaluated between pipeline registers; SHALL divide DATA_WIDTH/BLOCK_WIDTH.
REQ-004 clk  input  1  single clock; all state on rising edge.
REQ-005 rst_n  input  1  synchronous, active-low reset.
REQ-006 in_valid  input  1  operand beat valid.
REQ-007 in_ready  output  1  block accepts beat when in_valid and in_ready are both 1.
REQ-008 mode  input  1  0 = add, 1 = subtract; sampled with the beat.
REQ-009 in1  input  DATA_WIDTH  first operand, unsigned.
REQ-010 in2  input  DATA_WIDTH  second operand, unsigned.
REQ-011 cin  input  1  carry-in (add) or borrow-in (subtract).
REQ-012 out_valid  output  1  result beat valid.
REQ-013 out_ready  input  1  downstream accepts result when out_valid and out_ready are both 1.
REQ-014 result  output  DATA_WIDTH+1  result; MSB is carry-out (add) or borrow-out (subtract).

Function
REQ-015 Add: result SHALL equal in1 + in2 + cin with zero-extended operands.
REQ-016 Subtract: result SHALL equal (in1 - in2 - cin) mod 2^(DATA_WIDTH+1); result[DATA_WIDTH] SHALL be 1 exactly when in1 < in2 + cin.
REQ-017 Subtract SHALL be implemented as in1 + ~in2 + !cin; the internal carry-out is inverted to form the borrow MSB.
REQ-018 Each block SHALL precompute both sums, for block carry-in 0 and for block carry-in 1, and select one with the incoming block carry.
REQ-019 NSTAGES = DATA_WIDTH/(BLOCK_WIDTH*BLOCKS_PER_STAGE).
  - Stage k resolves blocks k*BLOCKS_PER_STAGE .. (k+1)*BLOCKS_PER_STAGE-1.
  - Stage k registers the partial result, the block carry, the mode and the not-yet-consumed upper operand bits.
REQ-020 Latency SHALL be NSTAGES cycles from an accepted input beat to out_valid, assuming no stall.
REQ-021 Each stage SHALL hold a valid bit. A stage loads when it is empty or when its contents move forward in the same cycle.
REQ-022 in_ready SHALL equal !valid[0] | ready into stage 0. Stage k's ready is !valid[k+1] | ready into stage k+1, and the last stage's ready is out_ready (combinational ripple).
REQ-023 Throughput SHALL be one beat per cycle while out_ready=1.
REQ-024 With out_ready=0, the pipeline SHALL fill bubbles, then hold all state; result and out_valid stay stable until accepted.
REQ-025 Beats SHALL exit in acceptance order, with no loss or duplication.
REQ-026 A per-beat mode change SHALL be honoured with no bubble between an add beat and a subtract beat.
REQ-027 Operands inside a stage whose valid bit is 0 SHALL not affect result.
REQ-028 Boundary values SHALL yield the exact arithmetic result with the correct MSB: all-zero and all-one operands, and cin=1 carries that propagate through every block.

Reset
REQ-029 While rst_n=0 at a clock edge:
  - all stage valid bits SHALL clear, so out_valid=0 the following cycle;
  - result SHALL reset to 0;
  - in_ready SHALL be 0 during reset and 1 in the first cycle after rst_n returns to 1.
REQ-030 Reset asserted mid-operation SHALL discard all in-flight beats; no partial result is emitted after reset.

Structure
REQ-031 A shared package SHALL hold the derived NSTAGES and NBLOCKS computations and the mode encoding constants MODE_ADD=0 and MODE_SUB=1.
REQ-032 A single sub-module csa_select_block SHALL be used.
  - Parameter: BLOCK_WIDTH.
  - Ports: a, b, cin → sum, cout.
  - It is combinational, containing the dual precompute and the select.
  - It is instantiated NBLOCKS times.
REQ-033 No other hierarchy is permitted; the stage registers and the handshake live in csa_addsub_pipe.

Verification (DATA_WIDTH=8, BLOCK_WIDTH=2, BLOCKS_PER_STAGE=2, latency 2)
REQ-034 Add with in1=0xFF, in2=0x01, cin=0 → result=0x100 two cycles after acceptance.
REQ-035 Subtract with in1=0x10, in2=0x20, cin=1 → result=0x1EF (borrow=1). Subtract with in1=0x20, in2=0x10, cin=0 → result=0x010.
REQ-036 Back-to-back beats alternating add and subtract, out_ready=1 → one result per cycle, in order, each matching the reference model.
REQ-037 out_ready held at 0 for 5 cycles with continuous input → in_ready drops after 2 accepted beats; the held result is stable; on release, all beats drain in order.
REQ-038 rst_n pulsed low for 1 cycle with 2 beats in flight → out_valid=0 from the next cycle; no stale result ever appears.
REQ-039 Random sweep of 10k beats with random in_valid/out_ready, and parameter sets (16,2,2), (16,4,1) and (32,4,4) → every result equals the model.
